// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the MEM-stage
// load/store controller.
package lsu_pkg;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [2:0] NB_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } lsu_state_e;

  // Encoding and alignment error; the range check needs MEM_WORDS and lives in the top.
  function automatic logic lsu_fmt_err(input logic wr, input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = lo[0];
      F3_W:    e = (lo != 2'b00);
      F3_BU:   e = wr;
      F3_HU:   e = wr | lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and data-memory signals of lsu_ctrl.
// slave = the controller, master = its environment (pipeline plus memory).
interface lsu_ctrl_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_rd;
  logic              mem_wr;
  logic [2:0]        mem_nb;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_rd, mem_wr, mem_nb, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_rd, mem_wr, mem_nb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: extended load value and read-modify-write merged word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mb;
  logic [31:0] w_mh;

  // Lane selection, merging and extension per access size.
  always_comb begin
    w_byte  = 8'h00;
    w_mb    = i_word;
    o_load  = 32'h0000_0000;
    o_merge = i_word;
    case (i_lane)
      2'd0: begin w_byte = i_word[7:0];   w_mb[7:0]   = i_wdata[7:0]; end
      2'd1: begin w_byte = i_word[15:8];  w_mb[15:8]  = i_wdata[7:0]; end
      2'd2: begin w_byte = i_word[23:16]; w_mb[23:16] = i_wdata[7:0]; end
      2'd3: begin w_byte = i_word[31:24]; w_mb[31:24] = i_wdata[7:0]; end
      default: begin w_byte = 8'h00; w_mb = i_word; end
    endcase
    if (i_lane[1]) begin
      w_half = i_word[31:16];
      w_mh   = {i_wdata[15:0], i_word[15:0]};
    end else begin
      w_half = i_word[15:0];
      w_mh   = {i_word[31:16], i_wdata[15:0]};
    end
    case (i_funct3)
      F3_B:    begin o_load = {{24{w_byte[7]}}, w_byte};  o_merge = w_mb;    end
      F3_H:    begin o_load = {{16{w_half[15]}}, w_half}; o_merge = w_mh;    end
      F3_W:    begin o_load = i_word;                     o_merge = i_wdata; end
      F3_BU:   begin o_load = {24'h000000, w_byte};       o_merge = i_word;  end
      F3_HU:   begin o_load = {16'h0000, w_half};         o_merge = i_word;  end
      default: begin o_load = 32'h0000_0000;              o_merge = i_word;  end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: word-wide memory accesses, sub-word loads
// with extension, read-modify-write for sb/sh, one-cycle response pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 101,
  parameter int ADDR_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus
);

  lsu_state_e        r_state;
  logic [1:0]        r_lane;
  logic [2:0]        r_funct3;
  logic              r_wr;
  logic [31:0]       r_wdata;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic [ADDR_W-1:0] w_word_idx;
  logic              w_err;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  assign w_word_idx = bus.req_addr >> 2;
  assign w_err      = lsu_fmt_err(bus.req_wr, bus.req_funct3, bus.req_addr[1:0]) |
                      (w_word_idx >= ADDR_W'(MEM_WORDS));

  lsu_lane_align u_align (
    .i_word   (bus.mem_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  assign bus.req_ready  = (r_state == ST_IDLE) & ~rst;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_nb     = NB_WORD;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

  // Request FSM with strobes and response registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lane       <= 2'b00;
      r_funct3     <= 3'b000;
      r_wr         <= 1'b0;
      r_wdata      <= 32'h0000_0000;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0000_0000;
          if (bus.req_valid) begin
            r_lane   <= bus.req_addr[1:0];
            r_funct3 <= bus.req_funct3;
            r_wr     <= bus.req_wr;
            r_wdata  <= bus.req_wdata;
            if (w_err) begin
              r_state      <= ST_DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_addr <= 32'(w_word_idx);
              // Only a full-word store skips the read; sb/sh need the old word.
              if (bus.req_wr && (bus.req_funct3 == F3_W)) begin
                r_state     <= ST_WRITE;
                r_mem_wr    <= 1'b1;
                r_mem_wdata <= bus.req_wdata;
              end else begin
                r_state  <= ST_READ;
                r_mem_rd <= 1'b1;
              end
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          r_mem_rd <= 1'b0;
          if (r_wr) begin
            r_state     <= ST_WRITE;
            r_mem_wr    <= 1'b1;
            r_mem_wdata <= w_merge;
          end else begin
            r_state      <= ST_DONE;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
          end
        end
        ST_WRITE: begin
          r_mem_wr     <= 1'b0;
          r_state      <= ST_DONE;
          r_resp_valid <= 1'b1;
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0000_0000;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized scoreboard bench for lsu_ctrl: a byte-lane memory model predicts
// each response, its latency, strobe counts and the written word.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 101;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          cyc;
    int          n_rd;
    int          n_wr;
    logic [31:0] idx;
    logic [31:0] wword;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] phys    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        pre_load = 1'b0;
  exp_t        q [$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          last_accept = 0;
  logic [31:0] last_rdata = 32'h0;
  bit          manual = 1'b0;
  int          man_wr = 0;
  int          man_resp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = (bus.mem_rd && (bus.mem_addr < 32'(MEM_WORDS))) ?
                         phys[bus.mem_addr[6:0]] : 32'h0;

  // Data memory: preload from the model image, otherwise accept word writes.
  always @(posedge clk) begin
    if (pre_load) begin
      for (int i = 0; i < MEM_WORDS; i++) phys[i] <= ref_mem[i];
    end else if (bus.mem_wr && (bus.mem_addr < 32'(MEM_WORDS))) begin
      phys[bus.mem_addr[6:0]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: size/alignment arithmetic on a plain word array.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    logic        legal;
    int          size;
    int          sh;
    logic [31:0] mask;
    logic [31:0] m;
    logic [31:0] v;
    legal = wr ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 <= 3'd5));
    size  = 1 << f3[1:0];
    sh    = int'(addr % 4) * 8;
    e.idx = addr >> 2;
    e.rdata = 32'h0;
    e.wword = 32'h0;
    if (!legal || ((addr % size) != 0) || (e.idx >= 32'(MEM_WORDS))) begin
      e.err = 1'b1; e.lat = 1; e.n_rd = 0; e.n_wr = 0;
    end else begin
      e.err = 1'b0;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
      if (!wr) begin
        v = (ref_mem[e.idx[6:0]] >> sh) & mask;
        if ((f3 < 3'd4) && (size < 4) && v[size*8-1]) v = v | ~mask;
        e.rdata = v; e.lat = 2; e.n_rd = 1; e.n_wr = 0;
      end else begin
        m = mask << sh;
        e.wword = (ref_mem[e.idx[6:0]] & ~m) | ((wd << sh) & m);
        ref_mem[e.idx[6:0]] = e.wword;
        e.lat  = (size == 4) ? 2 : 3;
        e.n_rd = (size == 4) ? 0 : 1;
        e.n_wr = 1;
      end
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_wr     = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=ready_low required=ready_high");
      bus.req_valid = 1'b0;
      return;
    end
    model(wr, f3, addr, wd, e);
    e.cyc = cyc + e.lat;
    q.push_back(e);
    last_accept = cyc + 1;
    @(posedge clk);
    #1;
    if (hold) begin
      // Junk request held while busy must be ignored.
      bus.req_wr     = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = $urandom_range(0, MEM_WORDS * 4);
      bus.req_wdata  = $urandom;
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: strobe address/data checks and response scoreboard.
  always @(negedge clk) begin
    if (manual) begin
      if (bus.mem_wr) man_wr++;
      if (bus.resp_valid) man_resp++;
    end else if (!rst) begin
      if (bus.mem_rd) begin
        rd_cnt++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_orphan actual=mem_rd required=idle");
        end else begin
          chk("rd_addr", bus.mem_addr, q[0].idx);
          chk("rd_nb", {29'b0, bus.mem_nb}, 32'd2);
        end
      end
      if (bus.mem_wr) begin
        wr_cnt++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_orphan actual=mem_wr required=idle");
        end else begin
          chk("wr_addr", bus.mem_addr, q[0].idx);
          chk("wr_data", bus.mem_wdata, q[0].wword);
        end
      end
      if (bus.resp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_orphan actual=resp_valid required=idle");
        end else begin
          mon_e = q.pop_front();
          chk("resp_err", {31'b0, bus.resp_err}, {31'b0, mon_e.err});
          chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
          chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rd_strobes", 32'(rd_cnt), 32'(mon_e.n_rd));
          chk("wr_strobes", 32'(wr_cnt), 32'(mon_e.n_wr));
          last_rdata = bus.resp_rdata;
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  initial begin
    int          a1;
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          hold;
    logic [2:0]  f3_tab [6];
    f3_tab[0] = F3_B; f3_tab[1] = F3_H; f3_tab[2] = F3_W;
    f3_tab[3] = F3_BU; f3_tab[4] = F3_HU; f3_tab[5] = F3_W;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
    ref_mem[14] = 32'h1122_3344;
    pre_load = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    pre_load = 1'b0;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

    issue(1'b1, F3_W, 32'h28, 32'h000F_69C8, 1'b0);
    drain();
    chk("sw_word10", phys[10], 32'h000F_69C8);
    issue(1'b1, F3_B, 32'h39, 32'hFFFF_FFC8, 1'b0);
    drain();
    chk("sb_word14", phys[14], 32'h1122_C844);
    issue(1'b0, F3_B, 32'h39, 32'h0, 1'b0);  drain(); chk("lb_plan", last_rdata, 32'hFFFF_FFC8);
    issue(1'b0, F3_BU, 32'h39, 32'h0, 1'b0); drain(); chk("lbu_plan", last_rdata, 32'h0000_00C8);
    issue(1'b0, F3_H, 32'h3A, 32'h0, 1'b0);  drain(); chk("lh_plan", last_rdata, 32'h0000_1122);
    issue(1'b0, F3_W, 32'h38, 32'h0, 1'b0);  drain(); chk("lw_plan", last_rdata, 32'h1122_C844);

    issue(1'b0, F3_W, 32'h2A, 32'h0, 1'b0);
    issue(1'b1, F3_H, 32'h29, 32'h1234, 1'b0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b0);
    issue(1'b0, F3_W, 32'h194, 32'h0, 1'b0);
    drain();

    issue(1'b1, F3_W, 32'h40, 32'hA5A5_0001, 1'b1);
    a1 = last_accept;
    issue(1'b1, F3_W, 32'h44, 32'h5A5A_0002, 1'b0);
    chk("b2b_gap", 32'(last_accept - a1), 32'd3);
    drain();

    for (int n = 0; n < 300; n++) begin
      f3   = ($urandom_range(0, 9) < 8) ? f3_tab[$urandom_range(0, 5)] : 3'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, MEM_WORDS * 4 + 11);
      hold = (n != 299) && ($urandom_range(0, 1) == 1);
      issue(1'($urandom), f3, addr, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    manual = 1'b1;
    man_wr = 0;
    man_resp = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h39; bus.req_wdata = 32'h0000_005A;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_read", {31'b0, bus.mem_rd}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_low", {31'b0, bus.req_ready}, 32'd0);
    chk("abort_idle_rd", {31'b0, bus.mem_rd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_high", {31'b0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_wr", 32'(man_wr), 32'd0);
    chk("abort_no_resp", 32'(man_resp), 32'd0);
    chk("abort_word14", phys[14], ref_mem[14]);
    manual = 1'b0;

    for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("mem_word%0d", i), phys[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
